// File: rtl/ripple_adder_pkg.sv
// Shared constants and the golden adder model for the ripple-carry adder slice.
package ripple_adder_pkg;

   localparam int RA_WIDTH_DEFAULT = 4;
   localparam int RA_WIDTH_MAX     = 32;

   // Result is (x + y + cin) truncated to width+1 bits, so the carry-out is bit [width].
   function automatic logic [RA_WIDTH_MAX:0] ra_ref_sum(
      input logic [RA_WIDTH_MAX-1:0] x,
      input logic [RA_WIDTH_MAX-1:0] y,
      input logic                    cin,
      input int unsigned             width
   );
      logic [RA_WIDTH_MAX:0] full_sum;
      logic [RA_WIDTH_MAX:0] mask;
      full_sum = {1'b0, x} + {1'b0, y} + {{RA_WIDTH_MAX{1'b0}}, cin};
      mask     = ({{RA_WIDTH_MAX{1'b0}}, 1'b1} << (width + 1)) - 1'b1;
      return full_sum & mask;
   endfunction

endpackage

// File: rtl/ripple_adder_behavioral_full_adder.sv
// Single-bit full adder cell used as one stage of the carry chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic half_sum;

   assign half_sum = a ^ b;
   assign s        = half_sum ^ cin;
   assign cout     = (a & b) | (cin & half_sum);

endmodule

// File: rtl/ripple_adder_behavioral.sv
// Registered unsigned ripple-carry adder: {Cout, S} = X + Y + Cin, one cycle latency.
// Define RIPPLE_ADDER_OVF_EN to add the registered two's-complement overflow output V.
module ripple_adder_behavioral
   import ripple_adder_pkg::*;
#(
   parameter int WIDTH = RA_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
`ifdef RIPPLE_ADDER_OVF_EN
   output logic             V,
`endif
   output logic             out_valid
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_next;

   assign carry[0] = Cin;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
         full_adder u_fa (
            .a    (X[gi]),
            .b    (Y[gi]),
            .cin  (carry[gi]),
            .s    (sum_next[gi]),
            .cout (carry[gi+1])
         );
      end
   endgenerate

   // Outputs only load on in_valid, so undriven operands in idle cycles never reach S/Cout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         S         <= '0;
         Cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            S    <= sum_next;
            Cout <= carry[WIDTH];
         end
      end
   end

`ifdef RIPPLE_ADDER_OVF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         V <= 1'b0;
      end else if (in_valid) begin
         V <= carry[WIDTH] ^ carry[WIDTH-1];
      end
   end
`endif

endmodule

// File: tb/tb_ripple_adder_behavioral.sv
// Self-checking bench: directed vector table plus random traffic on 4-bit and 16-bit adders.
module tb_ripple_adder_behavioral;
   import ripple_adder_pkg::*;

   localparam int W4  = 4;
   localparam int W16 = 16;
   localparam int NVEC = 10;

   typedef struct {
      logic [3:0] x;
      logic [3:0] y;
      logic       cin;
      logic [3:0] s;
      logic       cout;
      logic       v;
   } vec_t;

   logic           clk;
   logic           rst_n;
   logic           iv4, iv16;
   logic [W4-1:0]  x4, y4, s4;
   logic [W16-1:0] x16, y16, s16;
   logic           ci4, ci16, co4, co16, ov4, ov16;
`ifdef RIPPLE_ADDER_OVF_EN
   logic           v4, v16;
`endif

   int checks;
   int errors;

   ripple_adder_behavioral #(.WIDTH(W4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv4),
      .X         (x4),
      .Y         (y4),
      .Cin       (ci4),
      .S         (s4),
      .Cout      (co4),
`ifdef RIPPLE_ADDER_OVF_EN
      .V         (v4),
`endif
      .out_valid (ov4)
   );

   ripple_adder_behavioral #(.WIDTH(W16)) dut16 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv16),
      .X         (x16),
      .Y         (y16),
      .Cin       (ci16),
      .S         (s16),
      .Cout      (co16),
`ifdef RIPPLE_ADDER_OVF_EN
      .V         (v16),
`endif
      .out_valid (ov16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Signed overflow: the true signed sum does not fit in w bits.
   function automatic bit signed_ovf(input longint unsigned x, input longint unsigned y,
                                     input bit cin, input int w);
      longint sx, sy, tot, lo, hi;
      sx  = (x >= (64'd1 << (w-1))) ? longint'(x) - (longint'(1) << w) : longint'(x);
      sy  = (y >= (64'd1 << (w-1))) ? longint'(y) - (longint'(1) << w) : longint'(y);
      tot = sx + sy + longint'(cin);
      lo  = -(longint'(1) << (w-1));
      hi  = (longint'(1) << (w-1)) - 1;
      return (tot < lo) || (tot > hi);
   endfunction

   vec_t tbl [NVEC];

   initial begin
      logic [W4-1:0]  e4_s;
      logic           e4_c, e4_v, e4_ov;
      logic [W16-1:0] e16_s;
      logic           e16_c, e16_v, e16_ov;
      logic [32:0]    r;

      checks = 0;
      errors = 0;

      tbl[0] = '{4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0};
      tbl[1] = '{4'h2, 4'h2, 1'b0, 4'h4, 1'b0, 1'b0};
      tbl[2] = '{4'h4, 4'h4, 1'b0, 4'h8, 1'b0, 1'b1};
      tbl[3] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
      tbl[4] = '{4'h1, 4'h1, 1'b1, 4'h3, 1'b0, 1'b0};
      tbl[5] = '{4'h2, 4'h2, 1'b1, 4'h5, 1'b0, 1'b0};
      tbl[6] = '{4'h4, 4'h4, 1'b1, 4'h9, 1'b0, 1'b1};
      tbl[7] = '{4'h8, 4'h8, 1'b1, 4'h1, 1'b1, 1'b1};
      tbl[8] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
      tbl[9] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};

      // Reset held with a live input on dut4; dut16 idles with unknown operands.
      rst_n = 1'b0;
      iv4 = 1'b1; x4 = 4'hF; y4 = 4'hF; ci4 = 1'b0;
      iv16 = 1'b0; x16 = 'x; y16 = 'x; ci16 = 1'bx;
      repeat (3) @(negedge clk);
      check("reset_s", s4, 0);
      check("reset_cout", co4, 0);
      check("reset_out_valid", ov4, 0);
`ifdef RIPPLE_ADDER_OVF_EN
      check("reset_v", v4, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);
      check("first_s", s4, 4'hE);
      check("first_cout", co4, 1);
      check("first_out_valid", ov4, 1);
      check("idle_x_s16", s16, 0);
      check("idle_x_cout16", co16, 0);
      check("idle_x_out_valid16", ov16, 0);

      // Back-to-back table: each vector checked one cycle after it is applied.
      x4 = tbl[0].x; y4 = tbl[0].y; ci4 = tbl[0].cin; iv4 = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
         @(negedge clk);
         check($sformatf("tbl%0d_s", i), s4, tbl[i].s);
         check($sformatf("tbl%0d_cout", i), co4, tbl[i].cout);
         check($sformatf("tbl%0d_out_valid", i), ov4, 1);
`ifdef RIPPLE_ADDER_OVF_EN
         check($sformatf("tbl%0d_v", i), v4, tbl[i].v);
`endif
         $display("vec %0d: %h+%h+%b -> S=%h Cout=%b", i, tbl[i].x, tbl[i].y, tbl[i].cin, s4, co4);
         if (i + 1 < NVEC) begin
            x4 = tbl[i+1].x; y4 = tbl[i+1].y; ci4 = tbl[i+1].cin;
         end else begin
            iv4 = 1'b0; x4 = 4'h3; y4 = 4'h5; ci4 = 1'b0;
         end
      end

      // Hold: in_valid low keeps S/Cout, drops out_valid.
      @(negedge clk);
      check("hold_s", s4, 4'hF);
      check("hold_cout", co4, 1);
      check("hold_out_valid", ov4, 0);
      x4 = 4'hA; y4 = 4'h9;
      @(negedge clk);
      check("hold2_s", s4, 4'hF);
      check("hold2_out_valid", ov4, 0);

      // Asynchronous reset in the middle of the high clock phase.
      iv4 = 1'b1; x4 = 4'h7; y4 = 4'h1; ci4 = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_s", s4, 4'h8);
      check("pre_rst_out_valid", ov4, 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_s", s4, 0);
      check("async_rst_cout", co4, 0);
      check("async_rst_out_valid", ov4, 0);
`ifdef RIPPLE_ADDER_OVF_EN
      check("async_rst_v", v4, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1; iv4 = 1'b0;

      // Random traffic against the arithmetic reference.
      e4_s = '0; e4_c = 1'b0; e4_v = 1'b0;
      e16_s = '0; e16_c = 1'b0; e16_v = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         iv4  = ($urandom_range(0, 7) != 0);
         iv16 = ($urandom_range(0, 7) != 0);
         x4 = 4'($urandom); y4 = 4'($urandom); ci4 = 1'($urandom);
         x16 = 16'($urandom); y16 = 16'($urandom); ci16 = 1'($urandom);
         if (iv4) begin
            r = ra_ref_sum(32'(x4), 32'(y4), ci4, W4);
            e4_s = r[W4-1:0]; e4_c = r[W4];
            e4_v = signed_ovf(64'(x4), 64'(y4), ci4, W4);
         end
         e4_ov = iv4;
         if (iv16) begin
            r = ra_ref_sum(32'(x16), 32'(y16), ci16, W16);
            e16_s = r[W16-1:0]; e16_c = r[W16];
            e16_v = signed_ovf(64'(x16), 64'(y16), ci16, W16);
         end
         e16_ov = iv16;
         @(negedge clk);
         check("rnd4_s", s4, e4_s);
         check("rnd4_cout", co4, e4_c);
         check("rnd4_out_valid", ov4, e4_ov);
         check("rnd16_s", s16, e16_s);
         check("rnd16_cout", co16, e16_c);
         check("rnd16_out_valid", ov16, e16_ov);
`ifdef RIPPLE_ADDER_OVF_EN
         check("rnd4_v", v4, e4_v);
         check("rnd16_v", v16, e16_v);
`endif
         if (i % 100 == 0)
            $display("rnd %0d: w4 S=%h Cout=%b  w16 S=%h Cout=%b", i, s4, co4, s16, co16);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
